// File: rtl/cpu_clk_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_clk_ctrl
//
// CPU clock-enable controller placed after the frequency divider chain. The
// divided clock is sampled in the fast clk domain and each rising edge becomes
// a single-cycle cpu_tick enable. Supports run / pause / single-step modes
// (step from a debounced push button) and stops while the CPU reports halt.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive stable cycles before the button level changes
//   CNT_W           : width of tick_count (wraps silently)
//
// Ports
//   clk          in   system clock, all logic on posedge
//   rst          in   synchronous active-high reset
//   slow_clk_in  in   divided clock, asynchronous to clk
//   btn_step     in   raw single-step push button, active-high, bouncy
//   sw_run       in   run switch (1 = run, 0 = pause), asynchronous
//   halt         in   CPU halt flag, already synchronous to clk
//   cpu_tick     out  registered 1-cycle clock enable for the CPU datapath
//   running      out  registered, high while in RUN
//   halted       out  registered, high while in HALTED
//   tick_count   out  number of cpu_tick pulses issued (wraps)
// -----------------------------------------------------------------------------
module cpu_clk_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             slow_clk_in,
    input  logic             btn_step,
    input  logic             sw_run,
    input  logic             halt,
    output logic             cpu_tick,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] tick_count
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        STEP   = 2'd2,
        HALTED = 2'd3
    } state_t;

    // Synchronisers: s1/s2 form the 2-FF synchroniser, slow_s3 holds the
    // previous synchronised level for edge detection.
    logic slow_s1, slow_s2, slow_s3;
    logic btn_s1, btn_s2;
    logic run_s1, run_s2;

    logic            btn_db;
    logic            btn_db_q;
    logic [DB_W-1:0] db_cnt;

    logic   slow_tick;
    logic   step_req;
    state_t state;
    state_t state_nx;
    logic   tick_nx;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            slow_s1 <= 1'b0;
            slow_s2 <= 1'b0;
            slow_s3 <= 1'b0;
            btn_s1  <= 1'b0;
            btn_s2  <= 1'b0;
            run_s1  <= 1'b0;
            run_s2  <= 1'b0;
        end else begin
            slow_s1 <= slow_clk_in;
            slow_s2 <= slow_s1;
            slow_s3 <= slow_s2;
            btn_s1  <= btn_step;
            btn_s2  <= btn_s1;
            run_s1  <= sw_run;
            run_s2  <= run_s1;
        end
    end

    assign slow_tick = slow_s2 & ~slow_s3;

    // Debounce: the accepted level follows the synchronised button only after
    // it has disagreed for DEBOUNCE_CYCLES consecutive cycles; any agreement
    // restarts the count, so a bounce shorter than that is discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_db   <= 1'b0;
            btn_db_q <= 1'b0;
            db_cnt   <= '0;
        end else begin
            btn_db_q <= btn_db;
            if (btn_s2 == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                btn_db <= btn_s2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    // Press only; releasing the button never requests a step.
    assign step_req = btn_db & ~btn_db_q;

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nx = state;
        tick_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (halt)          state_nx = HALTED;
                else if (run_s2)   state_nx = RUN;
                else if (step_req) state_nx = STEP;
            end
            RUN: begin
                // Leaving RUN suppresses a coincident tick.
                if (halt)         state_nx = HALTED;
                else if (!run_s2) state_nx = IDLE;
                else              tick_nx  = slow_tick;
            end
            STEP: begin
                // Further presses are not queued; the run switch is only
                // looked at again once back in IDLE.
                if (halt) begin
                    state_nx = HALTED;
                end else if (slow_tick) begin
                    tick_nx  = 1'b1;
                    state_nx = IDLE;
                end
            end
            HALTED: begin
                // Never resume straight into RUN: the switch must be off.
                if (!halt && !run_s2) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Status flags are registered from the next state so they line up with
    // the state register rather than lagging it by a cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cpu_tick   <= 1'b0;
            running    <= 1'b0;
            halted     <= 1'b0;
            tick_count <= '0;
        end else begin
            state    <= state_nx;
            cpu_tick <= tick_nx;
            running  <= (state_nx == RUN);
            halted   <= (state_nx == HALTED);
            if (tick_nx) tick_count <= tick_count + CNT_W'(1);
        end
    end

endmodule
